// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: state encoding,
// digit widths and the blank masks used to blink the field under adjustment.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJ    = 2'd2
  } state_t;

  localparam int TENS_W = 3;
  localparam int ONES_W = 4;

  localparam logic [3:0] BLANK_NONE = 4'b0000;
  localparam logic [3:0] BLANK_MIN  = 4'b1100;
  localparam logic [3:0] BLANK_SEC  = 4'b0011;

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after MAX; carry flags the wrap so a
// higher field can be advanced in the same cycle.
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [TENS_W-1:0] tens,
  output logic [ONES_W-1:0] ones,
  output logic              carry
);

  localparam logic [TENS_W-1:0] MAX_TENS = TENS_W'(MAX / 10);
  localparam logic [ONES_W-1:0] MAX_ONES = ONES_W'(MAX % 10);

  logic [6:0] value;
  logic       at_max;
  logic       wrap;

  // Anything at or beyond MAX, including forced non-BCD ones, wraps to 00.
  assign value  = 7'(tens) * 7'd10 + 7'(ones);
  assign at_max = (tens == MAX_TENS) && (ones == MAX_ONES);
  assign wrap   = (ones > 4'd9) || (value >= 7'(MAX));
  assign carry  = inc && at_max;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tens <= '0;
      ones <= '0;
    end else if (inc) begin
      if (wrap) begin
        tens <= '0;
        ones <= '0;
      end else if (ones == 4'd9) begin
        tens <= tens + 3'd1;
        ones <= '0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch time base: run/pause/adjust FSM, BCD minute and second fields,
// and the blink mask that lets the display flash the field being adjusted.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN  = 59,
  parameter bit BLINK_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              tick_2hz,
  input  logic              pause_p,
  input  logic              clear_p,
  input  logic              sw_adj,
  input  logic              sw_sel,
  output logic [TENS_W-1:0] minhv,
  output logic [ONES_W-1:0] minlv,
  output logic [TENS_W-1:0] sechv,
  output logic [ONES_W-1:0] seclv,
  output logic [3:0]        blank,
  output logic              running
);

  state_t     state;
  state_t     state_next;
  logic       phase;
  logic       phase_next;
  logic [3:0] blank_next;

  logic adj_tick;
  logic sec_inc;
  logic sec_carry;
  logic min_inc;
  logic min_carry;
  logic min_clr;

  // In ADJ the fields advance independently; only RUN chains seconds into minutes.
  assign adj_tick = (state == ADJ) && tick_2hz;
  assign sec_inc  = ((state == RUN) && tick_1hz) || (adj_tick && sw_sel);
  assign min_inc  = ((state == RUN) && sec_carry) || (adj_tick && !sw_sel);
  assign min_clr  = clear_p || min_carry;

  bcd_mod_counter #(.MAX(59)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear_p),
    .inc   (sec_inc),
    .tens  (sechv),
    .ones  (seclv),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
    .clk   (clk),
    .rst   (rst),
    .clr   (min_clr),
    .inc   (min_inc),
    .tens  (minhv),
    .ones  (minlv),
    .carry (min_carry)
  );

  always_comb begin
    state_next = state;
    phase_next = 1'b0;
    blank_next = BLANK_NONE;

    unique case (state)
      PAUSED: begin
        if (sw_adj)       state_next = ADJ;
        else if (pause_p) state_next = RUN;
      end
      RUN: begin
        if (sw_adj)       state_next = ADJ;
        else if (pause_p) state_next = PAUSED;
      end
      ADJ: begin
        if (!sw_adj)      state_next = PAUSED;
      end
      default:            state_next = PAUSED;
    endcase

    // Phase restarts at 0 whenever ADJ is (re)entered.
    if (state == ADJ && state_next == ADJ)
      phase_next = phase ^ tick_2hz;

    if (BLINK_EN && state_next == ADJ && phase_next)
      blank_next = sw_sel ? BLANK_SEC : BLANK_MIN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PAUSED;
      phase   <= 1'b0;
      blank   <= BLANK_NONE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      phase   <= phase_next;
      blank   <= blank_next;
      running <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl: counting, wrap, pause,
// adjust/blink, clear and reset scenarios with hand-computed expectations.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       pause_p;
  logic       clear_p;
  logic       sw_adj;
  logic       sw_sel;
  logic [2:0] minhv;
  logic [3:0] minlv;
  logic [2:0] sechv;
  logic [3:0] seclv;
  logic [3:0] blank;
  logic       running;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .tick_2hz (tick_2hz),
    .pause_p  (pause_p),
    .clear_p  (clear_p),
    .sw_adj   (sw_adj),
    .sw_sel   (sw_sel),
    .minhv    (minhv),
    .minlv    (minlv),
    .sechv    (sechv),
    .seclv    (seclv),
    .blank    (blank),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] bcd_time(input int m, input int s);
    return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [13:0] shown();
    return {minhv, minlv, sechv, seclv};
  endfunction

  // Inputs change on the falling edge; results are read on the next falling edge.
  task automatic drive(input logic t1, input logic t2, input logic p, input logic c);
    tick_1hz = t1;
    tick_2hz = t2;
    pause_p  = p;
    clear_p  = c;
    @(negedge clk);
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
    pause_p  = 1'b0;
    clear_p  = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic ticks_1hz(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ticks_2hz(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; sw_adj = 1'b1; sw_sel = 1'b1;
    tick_1hz = 1'b1; tick_2hz = 1'b1; pause_p = 1'b1; clear_p = 1'b0;
    idle();
    idle();
    checks++;
    if (shown() !== bcd_time(0, 0)) begin
      errors++; $display("[TB] FAIL reset_time: got %h expected %h", shown(), bcd_time(0, 0));
    end
    checks++;
    if (blank !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_blank: got %b expected 0000", blank);
    end
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_running: got %b expected 0", running);
    end
    rst = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
    tick_1hz = 1'b0; tick_2hz = 1'b0; pause_p = 1'b0;
    ticks_1hz(2);
    checks++;
    if (shown() !== bcd_time(0, 0) || running !== 1'b0) begin
      errors++; $display("[TB] FAIL paused_no_count: got %h run=%b expected %h run=0", shown(), running, bcd_time(0, 0));
    end
  endtask

  task automatic test_count();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("[TB] FAIL start_running: got %b expected 1", running);
    end
    ticks_1hz(60);
    checks++;
    if (shown() !== bcd_time(1, 0)) begin
      errors++; $display("[TB] FAIL count_60: got %h expected %h", shown(), bcd_time(1, 0));
    end
    ticks_1hz(1);
    checks++;
    if (shown() !== bcd_time(1, 1) || running !== 1'b1) begin
      errors++; $display("[TB] FAIL count_61: got %h run=%b expected %h run=1", shown(), running, bcd_time(1, 1));
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (shown() !== bcd_time(0, 0) || running !== 1'b1) begin
      errors++; $display("[TB] FAIL clear_in_run: got %h run=%b expected %h run=1", shown(), running, bcd_time(0, 0));
    end
    sw_adj = 1'b1; sw_sel = 1'b0;
    idle();
    ticks_2hz(59);
    sw_sel = 1'b1;
    ticks_2hz(58);
    checks++;
    if (shown() !== bcd_time(59, 58) || running !== 1'b0) begin
      errors++; $display("[TB] FAIL preload_5958: got %h run=%b expected %h run=0", shown(), running, bcd_time(59, 58));
    end
    sw_adj = 1'b0;
    idle();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    ticks_1hz(1);
    checks++;
    if (shown() !== bcd_time(59, 59)) begin
      errors++; $display("[TB] FAIL wrap_5959: got %h expected %h", shown(), bcd_time(59, 59));
    end
    ticks_1hz(1);
    checks++;
    if (shown() !== bcd_time(0, 0)) begin
      errors++; $display("[TB] FAIL wrap_0000: got %h expected %h", shown(), bcd_time(0, 0));
    end
  endtask

  task automatic test_pause_tick();
    ticks_1hz(5);
    checks++;
    if (shown() !== bcd_time(0, 5)) begin
      errors++; $display("[TB] FAIL run_0005: got %h expected %h", shown(), bcd_time(0, 5));
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (shown() !== bcd_time(0, 6) || running !== 1'b0) begin
      errors++; $display("[TB] FAIL pause_with_tick: got %h run=%b expected %h run=0", shown(), running, bcd_time(0, 6));
    end
    ticks_1hz(3);
    checks++;
    if (shown() !== bcd_time(0, 6)) begin
      errors++; $display("[TB] FAIL paused_hold: got %h expected %h", shown(), bcd_time(0, 6));
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (shown() !== bcd_time(0, 6) || running !== 1'b1) begin
      errors++; $display("[TB] FAIL resume_with_tick: got %h run=%b expected %h run=1", shown(), running, bcd_time(0, 6));
    end
  endtask

  task automatic test_adjust();
    logic [13:0] exp_t [3];
    logic [3:0]  exp_b [3];
    exp_t[0] = bcd_time(0, 59); exp_b[0] = 4'b0011;
    exp_t[1] = bcd_time(0, 0);  exp_b[1] = 4'b0000;
    exp_t[2] = bcd_time(0, 1);  exp_b[2] = 4'b0011;

    sw_adj = 1'b1; sw_sel = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (shown() !== bcd_time(0, 7) || running !== 1'b0 || blank !== 4'b0000) begin
      errors++; $display("[TB] FAIL adj_entry_with_tick: got %h run=%b blank=%b expected %h run=0 blank=0000", shown(), running, blank, bcd_time(0, 7));
    end
    ticks_2hz(51);
    checks++;
    if (shown() !== bcd_time(0, 58) || blank !== 4'b0011) begin
      errors++; $display("[TB] FAIL adj_0058: got %h blank=%b expected %h blank=0011", shown(), blank, bcd_time(0, 58));
    end
    sw_adj = 1'b0;
    idle();
    sw_adj = 1'b1;
    idle();
    checks++;
    if (blank !== 4'b0000) begin
      errors++; $display("[TB] FAIL adj_reentry_phase: got %b expected 0000", blank);
    end
    for (int i = 0; i < 3; i++) begin
      ticks_2hz(1);
      checks++;
      if (shown() !== exp_t[i] || blank !== exp_b[i]) begin
        errors++; $display("[TB] FAIL adj_sec_step%0d: got %h blank=%b expected %h blank=%b", i, shown(), blank, exp_t[i], exp_b[i]);
      end
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (shown() !== bcd_time(0, 1) || running !== 1'b0 || blank !== 4'b0011) begin
      errors++; $display("[TB] FAIL adj_ignores_1hz_pause: got %h run=%b blank=%b expected %h run=0 blank=0011", shown(), running, blank, bcd_time(0, 1));
    end
    sw_sel = 1'b0;
    idle();
    checks++;
    if (blank !== 4'b1100 || shown() !== bcd_time(0, 1)) begin
      errors++; $display("[TB] FAIL sel_change_blank: got %h blank=%b expected %h blank=1100", shown(), blank, bcd_time(0, 1));
    end
    ticks_2hz(1);
    checks++;
    if (shown() !== bcd_time(1, 1) || blank !== 4'b0000) begin
      errors++; $display("[TB] FAIL adj_min_step: got %h blank=%b expected %h blank=0000", shown(), blank, bcd_time(1, 1));
    end
  endtask

  task automatic test_clear_tick();
    ticks_2hz(11);
    sw_sel = 1'b1;
    ticks_2hz(33);
    sw_adj = 1'b0;
    idle();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (shown() !== bcd_time(12, 34) || running !== 1'b1) begin
      errors++; $display("[TB] FAIL setup_1234: got %h run=%b expected %h run=1", shown(), running, bcd_time(12, 34));
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (shown() !== bcd_time(0, 0) || running !== 1'b1) begin
      errors++; $display("[TB] FAIL clear_with_tick: got %h run=%b expected %h run=1", shown(), running, bcd_time(0, 0));
    end
    ticks_1hz(1);
    checks++;
    if (shown() !== bcd_time(0, 1)) begin
      errors++; $display("[TB] FAIL tick_after_clear: got %h expected %h", shown(), bcd_time(0, 1));
    end
  endtask

  task automatic test_reset_adj();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    sw_adj = 1'b1; sw_sel = 1'b0;
    idle();
    ticks_2hz(7);
    sw_sel = 1'b1;
    ticks_2hz(30);
    checks++;
    if (shown() !== bcd_time(7, 30) || blank !== 4'b0011) begin
      errors++; $display("[TB] FAIL setup_0730: got %h blank=%b expected %h blank=0011", shown(), blank, bcd_time(7, 30));
    end
    rst = 1'b1; sw_adj = 1'b0;
    idle();
    rst = 1'b0;
    checks++;
    if (shown() !== bcd_time(0, 0) || blank !== 4'b0000 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid_adj: got %h blank=%b run=%b expected %h blank=0000 run=0", shown(), blank, running, bcd_time(0, 0));
    end
    ticks_2hz(4);
    checks++;
    if (shown() !== bcd_time(0, 0)) begin
      errors++; $display("[TB] FAIL 2hz_ignored_paused: got %h expected %h", shown(), bcd_time(0, 0));
    end
    sw_adj = 1'b1;
    idle();
    ticks_2hz(1);
    checks++;
    if (shown() !== bcd_time(0, 1) || blank !== 4'b0011) begin
      errors++; $display("[TB] FAIL adj_after_reset: got %h blank=%b expected %h blank=0011", shown(), blank, bcd_time(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_pause_tick();
    test_adjust();
    test_clear_tick();
    test_reset_adj();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
